// File: rtl/hazard_tracker_if.sv
// Operand-forwarding / hazard control interface between the ID stage and the
// hazard tracker.
//
// ID-side inputs : Rd_ID, RegWrite_ID, MemRead_ID, setFlag_ID, valid_ID,
//                  Rn, Rm, useRn, useRm, taken_branch, mem_busy, cnt_clear
// Tracker outputs: Rd_EX, RegWrite_EX, MemRead_EX, setFlag_EX, Rd_MEM,
//                  RegWrite_MEM, stall_pc, stall_ifid, flush_ifid, bubble_ex,
//                  stall_count
//
// Modports: slave  = the hazard tracker (consumes ID info, drives controls)
//           master = the pipeline side that presents ID info
//
// Handshake: there is no valid/ready pair here. valid_ID qualifies the ID
// fields for the cycle they are presented. The stall/flush/bubble controls are
// level signals that apply to the clock edge that ends the same cycle.
interface hazard_tracker_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rd_ID;
  logic             RegWrite_ID;
  logic             MemRead_ID;
  logic             setFlag_ID;
  logic             valid_ID;
  logic [4:0]       Rn;
  logic [4:0]       Rm;
  logic             useRn;
  logic             useRm;
  logic             taken_branch;
  logic             mem_busy;
  logic             cnt_clear;

  logic [4:0]       Rd_EX;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic             setFlag_EX;
  logic [4:0]       Rd_MEM;
  logic             RegWrite_MEM;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             bubble_ex;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  Rd_ID, RegWrite_ID, MemRead_ID, setFlag_ID, valid_ID,
    input  Rn, Rm, useRn, useRm, taken_branch, mem_busy, cnt_clear,
    output Rd_EX, RegWrite_EX, MemRead_EX, setFlag_EX, Rd_MEM, RegWrite_MEM,
    output stall_pc, stall_ifid, flush_ifid, bubble_ex, stall_count
  );

  modport master (
    output Rd_ID, RegWrite_ID, MemRead_ID, setFlag_ID, valid_ID,
    output Rn, Rm, useRn, useRm, taken_branch, mem_busy, cnt_clear,
    input  Rd_EX, RegWrite_EX, MemRead_EX, setFlag_EX, Rd_MEM, RegWrite_MEM,
    input  stall_pc, stall_ifid, flush_ifid, bubble_ex, stall_count
  );
endinterface

// File: rtl/hazard_tracker.sv
// Hazard tracker for the 5-stage pipeline: the producer side of operand
// forwarding. Tracks destination/write/load/flag info for the EX and MEM
// instructions, detects load-use hazards (one bubble each), squashes the
// fetched successor of a taken branch and freezes everything while data
// memory is busy. A saturating counter records load-use stall cycles.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - hazard_tracker_if.slave (ID info in, slot info and controls out)
//
// CNT_W must match the CNT_W of the connected interface instance.
module hazard_tracker #(
  parameter int CNT_W = 16,
  parameter int ZR    = 31
) (
  input  logic           clk,
  input  logic           reset,
  hazard_tracker_if.slave bus
);

  localparam logic [4:0]       ZR_IDX  = 5'(ZR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // EX slot
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic       ex_setflag;

  // MEM slot
  logic       mem_valid;
  logic [4:0] mem_rd;
  logic       mem_regwrite;

  logic [CNT_W-1:0] stall_count;

  logic load_use;

  // A load writing ZR produces nothing to wait for, so it never stalls.
  // Reset forces the hazard off so every control is quiet during reset.
  always_comb begin
    load_use = 1'b0;
    if (!reset && ex_valid && ex_memread && ex_regwrite && ex_rd != ZR_IDX) begin
      load_use = (bus.useRn && bus.Rn == ex_rd) || (bus.useRm && bus.Rm == ex_rd);
    end
  end

  // Controls: mem_busy wins, then load_use, then taken_branch. A branch seen
  // during a load-use stall is dropped; it resolves again after the bubble.
  always_comb begin
    bus.stall_pc   = bus.mem_busy || load_use;
    bus.stall_ifid = bus.mem_busy || load_use;
    bus.bubble_ex  = !bus.mem_busy && load_use;
    bus.flush_ifid = !reset && !bus.mem_busy && !load_use && bus.taken_branch;
  end

  // Slot pipeline. The branch itself advances into EX; only IF/ID is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rd        <= ZR_IDX;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_setflag   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= ZR_IDX;
      mem_regwrite <= 1'b0;
    end else if (!bus.mem_busy) begin
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (load_use) begin
        ex_valid    <= 1'b0;
        ex_rd       <= ZR_IDX;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_setflag  <= 1'b0;
      end else begin
        ex_valid    <= bus.valid_ID;
        ex_rd       <= bus.Rd_ID;
        ex_regwrite <= bus.RegWrite_ID;
        ex_memread  <= bus.MemRead_ID;
        ex_setflag  <= bus.setFlag_ID;
      end
    end
  end

  // Counts only real bubble insertions (not frozen cycles); clear beats a
  // same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (bus.cnt_clear) begin
      stall_count <= '0;
    end else if (!bus.mem_busy && load_use && stall_count != CNT_MAX) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Invalid slots present ZR with all flags low.
  always_comb begin
    bus.Rd_EX        = ex_valid  ? ex_rd  : ZR_IDX;
    bus.RegWrite_EX  = ex_valid  && ex_regwrite;
    bus.MemRead_EX   = ex_valid  && ex_memread;
    bus.setFlag_EX   = ex_valid  && ex_setflag;
    bus.Rd_MEM       = mem_valid ? mem_rd : ZR_IDX;
    bus.RegWrite_MEM = mem_valid && mem_regwrite;
    bus.stall_count  = stall_count;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed, table-driven bench for hazard_tracker. Each table row is one
// clock cycle: the ID inputs presented in that cycle and the outputs expected
// before the closing edge. The counter width is reduced so saturation is
// reachable in a short run.
module tb_hazard_tracker;

  localparam int CNT_W = 8;
  localparam int OUT_W = 18 + CNT_W;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int NV    = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_tracker_if #(.CNT_W(CNT_W)) bus ();

  hazard_tracker #(.CNT_W(CNT_W), .ZR(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int rd_id, rw_id, mr_id, sf_id, v_id;
    int rn, rm, urn, urm;
    int tb, mb, clr;
    int e_rd_ex, e_rw_ex, e_mr_ex, e_sf_ex;
    int e_rd_mem, e_rw_mem;
    int e_spc, e_sif, e_fl, e_bub;
    int e_cnt;
  } vec_t;

  vec_t vecs [NV];
  logic [OUT_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic drive_in(input vec_t v);
    bus.Rd_ID        = 5'(v.rd_id);
    bus.RegWrite_ID  = 1'(v.rw_id);
    bus.MemRead_ID   = 1'(v.mr_id);
    bus.setFlag_ID   = 1'(v.sf_id);
    bus.valid_ID     = 1'(v.v_id);
    bus.Rn           = 5'(v.rn);
    bus.Rm           = 5'(v.rm);
    bus.useRn        = 1'(v.urn);
    bus.useRm        = 1'(v.urm);
    bus.taken_branch = 1'(v.tb);
    bus.mem_busy     = 1'(v.mb);
    bus.cnt_clear    = 1'(v.clr);
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0};
    drive_in(v);
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [OUT_W-1:0] pack_exp(input vec_t v);
    return {5'(v.e_rd_ex), 1'(v.e_rw_ex), 1'(v.e_mr_ex), 1'(v.e_sf_ex),
            5'(v.e_rd_mem), 1'(v.e_rw_mem),
            1'(v.e_spc), 1'(v.e_sif), 1'(v.e_fl), 1'(v.e_bub),
            CNT_W'(v.e_cnt)};
  endfunction

  function automatic logic [OUT_W-1:0] pack_act();
    return {bus.Rd_EX, bus.RegWrite_EX, bus.MemRead_EX, bus.setFlag_EX,
            bus.Rd_MEM, bus.RegWrite_MEM,
            bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.bubble_ex,
            bus.stall_count};
  endfunction

  // Output vector layout: rd_ex,rw_ex,mr_ex,sf_ex,rd_mem,rw_mem,spc,sif,fl,bub,cnt
  task automatic check_out(input string name);
    logic [OUT_W-1:0] e;
    logic [OUT_W-1:0] a;
    e = exp_q.pop_front();
    a = pack_act();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv;

    //          rd rw mr sf v   rn rm urn urm tb mb clr | rdEX rw mr sf rdMEM rw spc sif fl bub cnt
    vecs[0]  = '{2, 1,1,0,1,  5, 0, 1,0,  0,0,0,  31,0,0,0, 31,0, 0,0,0,0, 0}; // LDUR X2
    vecs[1]  = '{4, 1,0,0,1,  2, 6, 1,1,  0,0,0,  2, 1,1,0, 31,0, 1,1,0,1, 0}; // ADD uses X2: stall
    vecs[2]  = '{4, 1,0,0,1,  2, 6, 1,1,  0,0,0,  31,0,0,0, 2, 1, 0,0,0,0, 1}; // bubble in EX, load in MEM
    vecs[3]  = '{31,1,1,0,1,  4, 0, 1,0,  0,0,0,  4, 1,0,0, 31,0, 0,0,0,0, 1}; // LDUR X31
    vecs[4]  = '{5, 1,0,0,1, 31,31, 1,1,  0,0,0,  31,1,1,0, 4, 1, 0,0,0,0, 1}; // ADD uses X31: no stall
    vecs[5]  = '{3, 1,0,1,1,  5, 1, 1,1,  0,0,0,  5, 1,0,0, 31,1, 0,0,0,0, 1}; // SUBS X3
    vecs[6]  = '{31,0,0,0,1,  0, 0, 0,0,  1,0,0,  3, 1,0,1, 5, 1, 0,0,1,0, 1}; // B.LT taken, flags from EX
    vecs[7]  = '{7, 1,1,1,0,  0, 0, 0,0,  0,0,0,  31,0,0,0, 3, 1, 0,0,0,0, 1}; // squashed slot (valid=0)
    vecs[8]  = '{9, 1,1,0,1,  7, 0, 1,0,  0,0,0,  31,0,0,0, 31,0, 0,0,0,0, 1}; // invalid EX never matches
    vecs[9]  = '{31,0,0,0,1,  0, 9, 0,1,  1,1,0,  9, 1,1,0, 31,0, 1,1,0,0, 1}; // busy over load_use+branch
    vecs[10] = '{31,0,0,0,1,  0, 9, 0,1,  1,1,0,  9, 1,1,0, 31,0, 1,1,0,0, 1}; // busy 2
    vecs[11] = '{31,0,0,0,1,  0, 9, 0,1,  1,1,0,  9, 1,1,0, 31,0, 1,1,0,0, 1}; // busy 3
    vecs[12] = '{31,0,0,0,1,  0, 9, 0,1,  1,0,0,  9, 1,1,0, 31,0, 1,1,0,1, 1}; // load_use beats branch
    vecs[13] = '{31,0,0,0,1,  0, 9, 0,1,  1,0,0,  31,0,0,0, 9, 1, 0,0,1,0, 2}; // branch re-resolves
    vecs[14] = '{0, 0,0,0,0,  0, 0, 0,0,  0,0,1,  31,0,0,0, 31,0, 0,0,0,0, 2}; // cnt_clear
    vecs[15] = '{0, 0,0,0,0,  0, 0, 0,0,  0,0,0,  31,0,0,0, 31,0, 0,0,0,0, 0};
    vecs[16] = '{8, 1,1,0,1,  0, 0, 0,0,  0,0,0,  31,0,0,0, 31,0, 0,0,0,0, 0}; // LDUR X8
    vecs[17] = '{31,0,0,0,1,  8, 8, 0,0,  0,0,0,  8, 1,1,0, 31,0, 0,0,0,0, 0}; // matches but not read
    vecs[18] = '{0, 0,0,0,0,  0, 0, 0,0,  0,0,0,  31,0,0,0, 8, 1, 0,0,0,0, 0};

    // Reset held 2 cycles with mem_busy low.
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rv = '{0,0,0,0,0, 0,0,0,0, 0,0,0, 31,0,0,0, 31,0, 0,0,0,0, 0};
    exp_q.push_back(pack_exp(rv));
    check_out("reset_idle");

    // Still in reset: mem_busy raises the stalls, a taken branch is ignored.
    bus.mem_busy     = 1'b1;
    bus.taken_branch = 1'b1;
    #1;
    rv = '{0,0,0,0,0, 0,0,0,0, 0,0,0, 31,0,0,0, 31,0, 1,1,0,0, 0};
    exp_q.push_back(pack_exp(rv));
    check_out("reset_busy");

    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle();

    for (int i = 0; i < NV; i++) begin
      drive_in(vecs[i]);
      exp_q.push_back(pack_exp(vecs[i]));
      @(negedge clk);
      check_out($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Saturation: a self-dependent load (LDUR X2,[X2]) held in ID stalls on
    // every odd cycle, starting from an empty EX slot.
    drive_idle();
    bus.Rd_ID       = 5'd2;
    bus.RegWrite_ID = 1'b1;
    bus.MemRead_ID  = 1'b1;
    bus.valid_ID    = 1'b1;
    bus.Rn          = 5'd2;
    bus.useRn       = 1'b1;
    for (int k = 0; k < 2 * (MAXV + 1) + 2; k++) begin
      @(negedge clk);
      if (k == 2 * (MAXV - 1)) check_val("cnt_before_sat", int'(bus.stall_count), MAXV - 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("cnt_saturated", int'(bus.stall_count), MAXV);
    @(posedge clk); #1;

    // Clear in a cycle that also stalls: the clear wins.
    bus.cnt_clear = 1'b1;
    @(negedge clk);
    check_val("bubble_with_clear", int'(bus.bubble_ex), 1);
    @(posedge clk); #1;
    bus.cnt_clear = 1'b0;
    @(negedge clk);
    check_val("cnt_cleared", int'(bus.stall_count), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("cnt_after_clear", int'(bus.stall_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
